// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and read-mask constants for the data-memory responder
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    localparam logic [3:0] MASK_WORD = 4'b1111;
    localparam logic [3:0] MASK_HLO  = 4'b0011;
    localparam logic [3:0] MASK_HHI  = 4'b1100;

endpackage

// File: rtl/dmem_responder_load_extend.sv
// rtl/dmem_responder_load_extend.sv - aligns and sign/zero-extends a sub-word load from the raw RAM word
module load_extend
    import dmem_responder_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [3:0]  memread_en,
    input  logic [1:0]  byteOff,
    input  logic        load_signed,
    output logic [31:0] ext
);

    logic [15:0] halfSel;
    logic [7:0]  byteSel;
    logic        halfLegal;
    logic        byteLegal;

    always_comb begin
        halfSel = byteOff[1] ? raw[31:16] : raw[15:0];
        byteSel = raw[7:0];
        case (byteOff)
            2'd0:    byteSel = raw[7:0];
            2'd1:    byteSel = raw[15:8];
            2'd2:    byteSel = raw[23:16];
            default: byteSel = raw[31:24];
        endcase

        halfLegal = ((memread_en == MASK_HLO) && (byteOff == 2'b00)) ||
                    ((memread_en == MASK_HHI) && (byteOff == 2'b10));
        byteLegal = (memread_en == (4'b0001 << byteOff));

        // Word reads and any mask/offset combination upstream will trap on pass the raw word through.
        ext = raw;
        if (halfLegal) begin
            ext = load_signed ? {{16{halfSel[15]}}, halfSel} : {16'h0000, halfSel};
        end else if (byteLegal) begin
            ext = load_signed ? {{24{byteSel[7]}}, byteSel} : {24'h000000, byteSel};
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with byte-masked writes and wait states
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [3:0]  memwrite_en,
    input  logic [3:0]  memread_en,
    input  logic [31:0] wdata,
    input  logic        load_signed,
    output logic        resp_valid,
    output logic [31:0] rdata_raw,
    output logic [31:0] rdata_ext,
    output logic        stall
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    stateT                 state;
    stateT                 nextState;
    logic [3:0]            waitCount;

    logic [ADDR_WIDTH-1:0] idxQ;
    logic [1:0]            offQ;
    logic [3:0]            wmaskQ;
    logic [3:0]            rmaskQ;
    logic [31:0]           wdataQ;
    logic                  signedQ;

    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  loadResp;
    logic [ADDR_WIDTH-1:0] effIdx;
    logic [1:0]            effOff;
    logic [3:0]            effWmask;
    logic [3:0]            effRmask;
    logic                  effSigned;
    logic                  isRead;
    logic [31:0]           ramWord;
    logic [31:0]           extWord;
    logic                  unusedAddrBits;

    assign unusedAddrBits = ^addr[31:ADDR_WIDTH+2];

    always_comb begin
        nextState  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (waitCount == 4'd0) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                resp_valid = ~rst;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign stall    = req_valid & ~resp_valid;
    assign accept   = (state == IDLE) && req_valid;
    assign loadResp = (nextState == RESP);

    // With zero wait states the response data is captured on the accept edge, so read from the live inputs.
    always_comb begin
        if (state == IDLE) begin
            effIdx    = addr[ADDR_WIDTH+1:2];
            effOff    = addr[1:0];
            effWmask  = memwrite_en;
            effRmask  = memread_en;
            effSigned = load_signed;
        end else begin
            effIdx    = idxQ;
            effOff    = offQ;
            effWmask  = wmaskQ;
            effRmask  = rmaskQ;
            effSigned = signedQ;
        end
        isRead  = (effWmask == 4'b0000) && (effRmask != 4'b0000);
        ramWord = mem[effIdx];
    end

    load_extend u_load_extend (
        .raw         (ramWord),
        .memread_en  (effRmask),
        .byteOff     (effOff),
        .load_signed (effSigned),
        .ext         (extWord)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            waitCount <= 4'd0;
            rdata_raw <= 32'h0;
            rdata_ext <= 32'h0;
        end else begin
            state <= nextState;
            if (accept) begin
                idxQ      <= addr[ADDR_WIDTH+1:2];
                offQ      <= addr[1:0];
                wmaskQ    <= memwrite_en;
                rmaskQ    <= memread_en;
                wdataQ    <= wdata;
                signedQ   <= load_signed;
                waitCount <= WAIT_INIT;
            end else if ((state == WAIT) && (waitCount != 4'd0)) begin
                waitCount <= waitCount - 4'd1;
            end
            if (loadResp) begin
                rdata_raw <= isRead ? ramWord : 32'h0;
                rdata_ext <= isRead ? extWord : 32'h0;
            end
        end
    end

    // A write landing in a reset cycle is dropped along with the rest of the request.
    always_ff @(posedge clk) begin
        if ((state == RESP) && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wmaskQ[i]) begin
                    mem[idxQ][8*i +: 8] <= wdataQ[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed checks of dmem_responder against a word-array model
module tb_dmem_responder;

    localparam int AW = 10;
    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [3:0]  memwrite_en;
    logic [3:0]  memread_en;
    logic [31:0] wdata;
    logic        load_signed;
    logic        resp_valid;
    logic [31:0] rdata_raw;
    logic [31:0] rdata_ext;
    logic        stall;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .addr        (addr),
        .memwrite_en (memwrite_en),
        .memread_en  (memread_en),
        .wdata       (wdata),
        .load_signed (load_signed),
        .resp_valid  (resp_valid),
        .rdata_raw   (rdata_raw),
        .rdata_ext   (rdata_ext),
        .stall       (stall)
    );

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] refMem [1 << AW];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refExtend(input logic [31:0] raw, input logic [3:0] rm,
                                              input logic [1:0] off, input logic sgn);
        int          offInt;
        logic [31:0] v;
        offInt = int'(off);
        if (rm == 4'hF) return raw;
        if ((rm == 4'b0011 && offInt == 0) || (rm == 4'b1100 && offInt == 2)) begin
            v = (raw >> (offInt * 8)) & 32'h0000FFFF;
            if (sgn && v >= 32'h00008000) v = v - 32'h00010000;
            return v;
        end
        if (int'(rm) == (1 << offInt)) begin
            v = (raw >> (offInt * 8)) & 32'h000000FF;
            if (sgn && v >= 32'h00000080) v = v - 32'h00000100;
            return v;
        end
        return raw;
    endfunction

    // Called at a falling edge; returns at the falling edge after the response cycle.
    task automatic doReq(input logic [31:0] a, input logic [3:0] wm, input logic [3:0] rm,
                         input logic [31:0] wd, input logic sg, input string tag,
                         output logic [31:0] gotRaw, output logic [31:0] gotExt);
        int          idx;
        int          cnt;
        int          badStall;
        int          badReady;
        logic [31:0] expRaw;
        logic [31:0] expExt;
        idx    = int'(a[AW+1:2]);
        expRaw = 32'h0;
        expExt = 32'h0;
        if (wm != 4'b0000) begin
            for (int i = 0; i < 4; i++)
                if (wm[i]) refMem[idx][8*i +: 8] = wd[8*i +: 8];
        end else if (rm != 4'b0000) begin
            expRaw = refMem[idx];
            expExt = refExtend(expRaw, rm, a[1:0], sg);
        end

        checkEq({tag, ":ready"}, 32'(req_ready), 32'd1);
        addr        = a;
        memwrite_en = wm;
        memread_en  = rm;
        wdata       = wd;
        load_signed = sg;
        req_valid   = 1'b1;
        cnt      = 0;
        badStall = 0;
        badReady = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (stall !== ~resp_valid) badStall++;
            if (!resp_valid && req_ready !== 1'b0) badReady++;
        end while (!resp_valid && cnt < 40);
        gotRaw = rdata_raw;
        gotExt = rdata_ext;
        checkEq({tag, ":latency"}, 32'(cnt), 32'(WC + 1));
        checkEq({tag, ":raw"}, gotRaw, expRaw);
        checkEq({tag, ":ext"}, gotExt, expExt);
        checkEq({tag, ":stall"}, 32'(badStall), 32'd0);
        checkEq({tag, ":busy"}, 32'(badReady), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        checkEq({tag, ":pulse"}, 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] r;
    logic [31:0] e;
    logic [31:0] saved;
    logic [3:0]  rmChoices [9];
    int          respSeen;

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        addr        = 32'h0;
        memwrite_en = 4'h0;
        memread_en  = 4'h0;
        wdata       = 32'h0;
        load_signed = 1'b0;
        rmChoices   = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h6};

        repeat (3) @(negedge clk);
        checkEq("rst:ready", 32'(req_ready), 32'd1);
        checkEq("rst:resp_valid", 32'(resp_valid), 32'd0);
        checkEq("rst:rdata_raw", rdata_raw, 32'h0);
        checkEq("rst:rdata_ext", rdata_ext, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < (1 << AW); i++)
            doReq(32'(i) << 2, 4'hF, 4'h0, $urandom, 1'b0, "init", r, e);

        doReq(32'h40, 4'hF, 4'h0, 32'hDEADBEEF, 1'b0, "w40", r, e);
        doReq(32'h40, 4'h0, 4'hF, 32'h0, 1'b0, "r40", r, e);
        checkEq("word:raw", r, 32'hDEADBEEF);
        checkEq("word:ext", e, 32'hDEADBEEF);

        doReq(32'h44, 4'hF, 4'h0, 32'h11223344, 1'b0, "w44", r, e);
        doReq(32'h44, 4'b0100, 4'h0, 32'hAAAAAAAA, 1'b0, "merge", r, e);
        doReq(32'h44, 4'h0, 4'hF, 32'h0, 1'b0, "r44", r, e);
        checkEq("merge:word", r, 32'h11AA3344);
        doReq(32'h46, 4'h0, 4'b0100, 32'h0, 1'b1, "sb46", r, e);
        checkEq("byte:signed", e, 32'hFFFFFFAA);
        doReq(32'h46, 4'h0, 4'b0100, 32'h0, 1'b0, "ub46", r, e);
        checkEq("byte:unsigned", e, 32'h000000AA);

        doReq(32'h48, 4'hF, 4'h0, 32'h80017FFE, 1'b0, "w48", r, e);
        doReq(32'h4A, 4'h0, 4'b1100, 32'h0, 1'b1, "sh4a", r, e);
        checkEq("half:hi_signed", e, 32'hFFFF8001);
        doReq(32'h4A, 4'h0, 4'b1100, 32'h0, 1'b0, "uh4a", r, e);
        checkEq("half:hi_unsigned", e, 32'h00008001);
        doReq(32'h48, 4'h0, 4'b0011, 32'h0, 1'b1, "sh48", r, e);
        checkEq("half:lo_signed", e, 32'h00007FFE);

        doReq(32'h48, 4'h0, 4'h0, 32'h12345678, 1'b0, "null", r, e);
        checkEq("null:raw", r, 32'h0);
        doReq(32'h48, 4'h0, 4'hF, 32'h0, 1'b0, "null_rb", r, e);
        checkEq("null:unchanged", r, 32'h80017FFE);

        doReq(32'h4C, 4'b0011, 4'hF, 32'h0000BBBB, 1'b0, "dbl", r, e);
        checkEq("dbl:ext", e, 32'h0);
        doReq(32'h4C, 4'h0, 4'hF, 32'h0, 1'b0, "dbl_rb", r, e);
        checkEq("dbl:lowhalf", r & 32'h0000FFFF, 32'h0000BBBB);

        saved       = refMem[32'h80 >> 2];
        addr        = 32'h80;
        memwrite_en = 4'hF;
        memread_en  = 4'h0;
        wdata       = ~saved;
        req_valid   = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkEq("rstwait:resp_valid", 32'(resp_valid), 32'd0);
        checkEq("rstwait:ready", 32'(req_ready), 32'd1);
        checkEq("rstwait:stall", 32'(stall), 32'd1);
        req_valid = 1'b0;
        rst       = 1'b0;
        respSeen  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) respSeen++;
        end
        checkEq("rstwait:no_resp", 32'(respSeen), 32'd0);
        checkEq("rstwait:stall_idle", 32'(stall), 32'd0);
        doReq(32'h80, 4'h0, 4'hF, 32'h0, 1'b0, "rstwait_rb", r, e);
        checkEq("rstwait:unchanged", r, saved);

        doReq(32'h1000, 4'hF, 4'h0, 32'hC0FFEE01, 1'b0, "wrap_w", r, e);
        doReq(32'h0000, 4'h0, 4'hF, 32'h0, 1'b0, "wrap_r", r, e);
        checkEq("wrap:word", r, 32'hC0FFEE01);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] wm;
            logic [3:0] rm;
            wm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            rm = ($urandom_range(0, 7) == 0) ? 4'($urandom) : rmChoices[$urandom_range(0, 8)];
            doReq($urandom, wm, rm, $urandom, 1'($urandom), "rand", r, e);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
